// File: rtl/usb_nrzi_tx.sv
// usb_nrzi_tx: USB full/low-speed serialiser with bit stuffing, NRZI encoding and EOP generation.
module usb_nrzi_tx #(
  parameter int STUFF_LIMIT = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_last,
  output logic in_ready,
  output logic DP_out,
  output logic DM_out,
  output logic sending,
  output logic done,
  output logic err
);
  localparam int CW = $clog2(STUFF_LIMIT + 1);
  typedef enum logic [2:0] {IDLE, DATA, EOP_SE0A, EOP_SE0B, EOP_J} state_t;
  state_t state, state_n;
  logic level, level_n, last_seen, last_n;
  logic dp_n, dm_n, sending_n, done_n, err_n;
  logic [CW-1:0] ones, ones_n;
  logic stuff, enc_base, bit_level;
  assign stuff = ones == CW'(STUFF_LIMIT);
  assign in_ready = state == IDLE || (state == DATA && !last_seen && !stuff);
  // every packet's NRZI encoding starts from J
  assign enc_base = state == IDLE ? 1'b1 : level;
  assign bit_level = in_bit ? enc_base : ~enc_base;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      level     <= 1'b1;
      ones      <= '0;
      last_seen <= 1'b0;
      DP_out    <= 1'b1;
      DM_out    <= 1'b0;
      sending   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      ones      <= ones_n;
      last_seen <= last_n;
      DP_out    <= dp_n;
      DM_out    <= dm_n;
      sending   <= sending_n;
      done      <= done_n;
      err       <= err_n;
    end
  end
  always_comb begin
    state_n   = state;
    level_n   = level;
    ones_n    = ones;
    last_n    = last_seen;
    dp_n      = DP_out;
    dm_n      = DM_out;
    sending_n = sending;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        dp_n = 1'b1;
        dm_n = 1'b0;
        if (in_valid) begin
          state_n   = DATA;
          level_n   = bit_level;
          ones_n    = CW'(in_bit);
          last_n    = in_last;
          dp_n      = bit_level;
          dm_n      = ~bit_level;
          sending_n = 1'b1;
        end
      end
      DATA: begin
        if (stuff) begin
          level_n = ~level;
          ones_n  = '0;
          dp_n    = ~level;
          dm_n    = level;
        end else if (last_seen || !in_valid) begin
          // normal end of packet, or underrun which still gets a full EOP
          state_n = EOP_SE0A;
          err_n   = !last_seen;
          dp_n    = 1'b0;
          dm_n    = 1'b0;
        end else begin
          level_n = bit_level;
          ones_n  = in_bit ? ones + 1'b1 : '0;
          last_n  = in_last;
          dp_n    = bit_level;
          dm_n    = ~bit_level;
        end
      end
      EOP_SE0A: begin
        state_n = EOP_SE0B;
        dp_n    = 1'b0;
        dm_n    = 1'b0;
      end
      EOP_SE0B: begin
        state_n = EOP_J;
        dp_n    = 1'b1;
        dm_n    = 1'b0;
      end
      EOP_J: begin
        state_n   = IDLE;
        ones_n    = '0;
        last_n    = 1'b0;
        dp_n      = 1'b1;
        dm_n      = 1'b0;
        sending_n = 1'b0;
        done_n    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_usb_nrzi_tx.sv
// tb_usb_nrzi_tx: directed packets with hand-computed bus sequences checked through a scoreboard queue.
module tb_usb_nrzi_tx;
  logic clock = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0;
  logic in_ready, DP_out, DM_out, sending, done, err;
  int checks = 0, failures = 0;
  // {sending, DP, DM, err, done}
  localparam logic [4:0] SJ = 5'b11000, SK = 5'b10100, SE = 5'b10000, SEE = 5'b10010, SD = 5'b01001;
  logic [4:0] exp_q[$];

  usb_nrzi_tx #(.STUFF_LIMIT(6)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
    .in_ready(in_ready), .DP_out(DP_out), .DM_out(DM_out), .sending(sending), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n && (sending || done || err)) begin
      logic [4:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL bus_extra got=%b required=none", {sending, DP_out, DM_out, err, done});
      end else begin
        e = exp_q.pop_front();
        if ({sending, DP_out, DM_out, err, done} !== e) begin
          failures++;
          $display("FAIL bus_symbol got=%b required=%b (sending,dp,dm,err,done)", {sending, DP_out, DM_out, err, done}, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++)
      case (s[i])
        "J": exp_q.push_back(SJ);
        "K": exp_q.push_back(SK);
        "0": exp_q.push_back(SE);
        "e": exp_q.push_back(SEE);
        default: exp_q.push_back(SD);
      endcase
  endtask

  task automatic send(input string name, input int n, input logic [15:0] bits, input bit has_last, input int exp_stalls);
    int st = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_bit = bits[i];
      in_last = has_last && i == n - 1;
      while (!in_ready && st < 20) begin
        @(negedge clock);
        st++;
      end
    end
    check({name, "_stalls"}, 8'(st), 8'(exp_stalls));
  endtask

  task automatic drop();
    @(negedge clock);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    check({name, "_drained"}, 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_low_sending", 8'(sending), 8'd0);
    reset_n = 1'b1;
    #1;
    check("rst_dp", 8'(DP_out), 8'd1);
    check("rst_dm", 8'(DM_out), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    check("rst_ready", 8'(in_ready), 8'd1);
    expect_str("KJJJ00Jd");
    send("basic", 4, 16'b1100, 1, 0);
    drop();
    drain("basic");
    expect_str("JJJJJJKK00Jd");
    send("seven_ones", 7, 16'h7f, 1, 1);
    drop();
    drain("seven_ones");
    expect_str("JJJJJJK00Jd");
    send("six_ones", 6, 16'h3f, 1, 0);
    drop();
    drain("six_ones");
    expect_str("KKJe0Jd");
    send("underrun", 3, 16'b010, 0, 0);
    drop();
    drain("underrun");
    expect_str("KKJ");
    send("abort", 3, 16'b010, 0, 0);
    @(negedge clock);
    in_bit = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("abort_sending", 8'(sending), 8'd0);
    check("abort_dp", 8'(DP_out), 8'd1);
    check("abort_dm", 8'(DM_out), 8'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1 check("abort_ready", 8'(in_ready), 8'd1);
    check("abort_queue", 8'(exp_q.size()), 8'd0);
    expect_str("JK00Jd");
    send("restart", 2, 16'b01, 1, 0);
    drop();
    drain("restart");
    expect_str("JJK00JdKK00Jd");
    send("b2b_a", 3, 16'b011, 1, 0);
    send("b2b_b", 2, 16'b10, 1, 4);
    drop();
    drain("b2b");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
